// File: rtl/axis_1553_msg_framer_pkg.sv
// Shared definitions for the 1553 message framer: tuser bit positions, command-word
// layout, FSM encoding and the expected-data-word-count helper.
package axis_1553_msg_framer_pkg;

    // Decoder-side tuser bits
    localparam int TUSER_CMD_SYNC  = 7;
    localparam int TUSER_DATA_SYNC = 6;
    localparam int TUSER_PERR      = 0;

    // Framer-side tuser bits
    localparam int OUT_IS_CMD = 7;
    localparam int OUT_ABORT  = 6;
    localparam int OUT_PERR   = 5;
    localparam int OUT_BCAST  = 4;

    typedef struct packed {
        logic [4:0] addr;
        logic       tr;
        logic [4:0] sa;
        logic [4:0] wc;
    } cmd_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_SKIP = 2'd2
    } state_t;

    // Number of data words that follow a command on the bus (receive side only).
    function automatic logic [5:0] wc_expected(input cmd_word_t cmd);
        logic [5:0] n;
        logic       unused_addr;
        unused_addr = ^cmd.addr;
        n = 6'd0;
        if (cmd.sa == 5'd0 || cmd.sa == 5'd31) begin
            if (!cmd.tr && cmd.wc[4]) n = 6'd1;
        end else if (!cmd.tr) begin
            n = (cmd.wc == 5'd0) ? 6'd32 : {1'b0, cmd.wc};
        end
        return n;
    endfunction

    function automatic logic [7:0] make_tuser(input logic is_cmd, input logic abort,
                                              input logic perr, input logic bcast);
        return {is_cmd, abort, perr, bcast, 4'b0000};
    endfunction

endpackage

// File: rtl/axis_1553_msg_framer_if.sv
// AXI-stream bundle shared by the decoder-facing and buffer-facing sides of the framer.
interface axis_1553_msg_framer_if #(
    parameter int DATA_W = 16,
    parameter int USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_1553_gap_timer.sv
// Loadable down-counter measuring the silence between accepted words of a message.
module axis_1553_gap_timer #(
    parameter int          W        = 12,
    parameter int unsigned LOAD_VAL = 2399
) (
    input  logic aclk,
    input  logic arst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(LOAD_VAL);
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/axis_1553_msg_framer.sv
// Groups decoded 1553 words into RT-addressed messages and emits them as a framed
// AXI stream with tlast on the final word and status flags in tuser.
module axis_1553_msg_framer
    import axis_1553_msg_framer_pkg::*;
#(
    parameter int unsigned clock_speed = 100000000,
    parameter int unsigned gap_us      = 24,
    parameter logic [4:0]  bcast_addr  = 5'd31
) (
    input  logic                          aclk,
    input  logic                          arst,
    input  logic [4:0]                    rt_addr,
    input  logic                          bcast_en,
    axis_1553_msg_framer_if.slave         s_axis,
    axis_1553_msg_framer_if.master        m_axis,
    output logic                          busy
);
    localparam longint unsigned GAP_CYCLES = (64'(gap_us) * 64'(clock_speed)) / 64'd1000000;
    localparam int              GAP_W      = $clog2(GAP_CYCLES + 64'd1);

    state_t      r_state, w_state_next;
    logic [5:0]  r_remaining, w_remaining_next;
    logic        r_bcast, w_bcast_next;
    logic        r_in_en;

    logic [15:0] r_m_tdata;
    logic [7:0]  r_m_tuser;
    logic        r_m_tvalid, r_m_tlast;

    cmd_word_t   w_cmd;
    logic [5:0]  w_n;
    logic        w_is_cmd, w_is_data, w_perr, w_match, w_is_bcast;
    logic        w_out_ready, w_stall_cmd, w_acc, w_gap_en, w_expired;
    logic        w_load, w_beat_last;
    logic [15:0] w_beat_data;
    logic [7:0]  w_beat_user;
    logic        w_unused_in;

    assign w_cmd       = cmd_word_t'(s_axis.tdata);
    assign w_is_cmd    = s_axis.tuser[TUSER_CMD_SYNC];
    assign w_is_data   = s_axis.tuser[TUSER_DATA_SYNC] & ~w_is_cmd;
    assign w_perr      = s_axis.tuser[TUSER_PERR];
    assign w_is_bcast  = bcast_en & (w_cmd.addr == bcast_addr);
    assign w_match     = (w_cmd.addr == rt_addr) | w_is_bcast;
    assign w_n         = wc_expected(w_cmd);
    assign w_unused_in = ^{s_axis.tlast, s_axis.tuser[5:1]};

    // A command arriving mid-message is held off for one beat so the abort goes out first.
    assign w_out_ready   = ~r_m_tvalid | m_axis.tready;
    assign w_stall_cmd   = (r_state == ST_DATA) & s_axis.tvalid & w_is_cmd;
    assign s_axis.tready = r_in_en & w_out_ready & ~w_stall_cmd;
    assign w_acc         = s_axis.tvalid & s_axis.tready;
    assign w_gap_en      = (r_state != ST_IDLE) & w_out_ready;

    axis_1553_gap_timer #(
        .W        (GAP_W),
        .LOAD_VAL (32'(GAP_CYCLES - 64'd1))
    ) u_gap_timer (
        .aclk      (aclk),
        .arst      (arst),
        .i_load    (w_acc),
        .i_en      (w_gap_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state     <= ST_IDLE;
            r_remaining <= 6'd0;
            r_bcast     <= 1'b0;
            r_in_en     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_bcast     <= w_bcast_next;
            r_in_en     <= 1'b1;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_bcast_next     = r_bcast;
        case (r_state)
            ST_IDLE, ST_SKIP: begin
                if (w_acc && w_is_cmd) begin
                    if (w_match && !w_perr) begin
                        w_bcast_next     = w_is_bcast;
                        w_remaining_next = w_n;
                        w_state_next     = (w_n == 6'd0) ? ST_IDLE : ST_DATA;
                    end else begin
                        w_state_next = ST_SKIP;
                    end
                end else if (r_state == ST_SKIP && w_expired) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_stall_cmd) begin
                    if (w_out_ready) w_state_next = ST_IDLE;
                end else if (w_acc && w_is_data) begin
                    w_remaining_next = r_remaining - 6'd1;
                    if (r_remaining == 6'd1) w_state_next = ST_IDLE;
                end else if (!w_acc && w_expired && w_out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_beat_data = 16'h0000;
        w_beat_user = 8'h00;
        w_beat_last = 1'b0;
        case (r_state)
            ST_IDLE, ST_SKIP: begin
                if (w_acc && w_is_cmd && w_match && !w_perr) begin
                    w_load      = 1'b1;
                    w_beat_data = s_axis.tdata;
                    w_beat_user = make_tuser(1'b1, 1'b0, 1'b0, w_is_bcast);
                    w_beat_last = (w_n == 6'd0);
                end
            end
            ST_DATA: begin
                if (w_stall_cmd || (!w_acc && w_expired)) begin
                    if (w_out_ready) begin
                        w_load      = 1'b1;
                        w_beat_user = make_tuser(1'b0, 1'b1, 1'b0, r_bcast);
                        w_beat_last = 1'b1;
                    end
                end else if (w_acc && w_is_data) begin
                    w_load      = 1'b1;
                    w_beat_data = s_axis.tdata;
                    w_beat_user = make_tuser(1'b0, 1'b0, w_perr, r_bcast);
                    w_beat_last = (r_remaining == 6'd1);
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= 16'h0000;
            r_m_tuser  <= 8'h00;
            r_m_tlast  <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_beat_data;
            r_m_tuser  <= w_beat_user;
            r_m_tlast  <= w_beat_last;
        end else if (m_axis.tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tuser  = r_m_tuser;
    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tlast  = r_m_tlast;
    assign busy          = (r_state != ST_IDLE);

endmodule
